// File: rtl/syscall_pkg.sv
// -----------------------------------------------------------------------------
// syscall_pkg
// Shared opcode constants and the FSM state type for syscall_unit.
// Configuration macro: SYSCALL_STRING_EN -- when defined, the string-print
// states (STR_RD, STR_CAP, STR_EMIT) are part of the state type.
// -----------------------------------------------------------------------------
package syscall_pkg;

   localparam int unsigned SYS_HALT  = 0;
   localparam int unsigned SYS_STORE = 1;
   localparam int unsigned SYS_LOAD  = 2;
   localparam int unsigned SYS_PNUM  = 3;
   localparam int unsigned SYS_PCHR  = 4;
   localparam int unsigned SYS_PSTR  = 5;

   typedef enum logic [3:0] {
      IDLE,
      WR,
      RD,
      RD_CAP,
      EMIT,
`ifdef SYSCALL_STRING_EN
      STR_RD,
      STR_CAP,
      STR_EMIT,
`endif
      HALT
   } state_t;

endpackage

// File: rtl/syscall_out_reg.sv
// -----------------------------------------------------------------------------
// syscall_out_reg
// One-entry holding register for the output token stream with a
// valid/ready handshake. A token loaded here stays stable until the
// consumer takes it.
// Ports:
//   clk, clear            clock and synchronous active-high reset
//   load                  capture load_data/load_kind as a new token
//   load_data, load_kind  token payload (kind 0 = character, 1 = number)
//   out_ready             consumer accepts the token
//   out_valid/out_data/out_kind  held token
//   xfer                  token transfers on this cycle's edge
// -----------------------------------------------------------------------------
module syscall_out_reg #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_kind,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_kind,
   output logic              xfer
);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q,  data_d;
   logic              kind_q,  kind_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      kind_d  = kind_q;
      // The controller only loads while the register is empty, so a load
      // never overwrites a pending token.
      if (load) begin
         valid_d = 1'b1;
         data_d  = load_data;
         kind_d  = load_kind;
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         kind_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         kind_q  <= kind_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_kind  = kind_q;
   assign xfer      = valid_q & out_ready;

endmodule

// File: rtl/syscall_unit.sv
// -----------------------------------------------------------------------------
// syscall_unit
// Executes one syscall per rising edge of sys_signal: halt, store, load,
// print number, print character and (optionally) print a zero-terminated
// string from memory.
// Configuration macro: SYSCALL_STRING_EN -- builds the string print
// (opcode 5); without it opcode 5 is treated as an unknown opcode.
// Ports:
//   clk, clear           clock, synchronous active-high reset
//   sys_signal, sysregs  request level and {arg1, arg0, opcode}
//   mem_*                single-port memory interface (read data 1 cycle late)
//   load_signal/data     result of the most recent load
//   out_valid/ready/data/kind  output token handshake
//   busy, done, halted, err    status
// -----------------------------------------------------------------------------
module syscall_unit
   import syscall_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 16,
   parameter int MAX_STR = 256
) (
   input  logic                clk,
   input  logic                clear,
   input  logic                sys_signal,
   input  logic [3*DATA_W-1:0] sysregs,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_we,
   output logic                mem_re,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                load_signal,
   output logic [DATA_W-1:0]   load_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W-1:0]   out_data,
   output logic                out_kind,
   output logic                busy,
   output logic                done,
   output logic                halted,
   output logic                err
);

   state_t            state_q, state_d;
   logic              sys_q;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              load_signal_q, load_signal_d;
   logic [DATA_W-1:0] load_data_q, load_data_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

`ifdef SYSCALL_STRING_EN
   localparam int CNT_W = $clog2(MAX_STR + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

   logic              rise;
   logic [DATA_W-1:0] op, arg0, arg1;
   logic              tok_load, tok_kind, xfer;
   logic [DATA_W-1:0] tok_data;

   assign rise = sys_signal & ~sys_q;
   assign op   = sysregs[DATA_W-1:0];
   assign arg0 = sysregs[2*DATA_W-1:DATA_W];
   assign arg1 = sysregs[3*DATA_W-1:2*DATA_W];

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      load_signal_d = load_signal_q;
      load_data_d   = load_data_q;
      done_d        = 1'b0;
      err_d         = err_q;
      tok_load      = 1'b0;
      tok_data      = '0;
      tok_kind      = 1'b0;
`ifdef SYSCALL_STRING_EN
      cnt_d         = cnt_q;
`endif

      // A request arriving outside IDLE (busy or halted) is dropped.
      if (rise && state_q != IDLE) err_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (rise) begin
               addr_d  = ADDR_W'(arg0);
               wdata_d = arg1;
               if (op != DATA_W'(SYS_LOAD)) load_signal_d = 1'b0;
               case (op)
                  DATA_W'(SYS_HALT):  state_d = HALT;
                  DATA_W'(SYS_STORE): state_d = WR;
                  DATA_W'(SYS_LOAD):  state_d = RD;
                  // Emits load the token register directly from sysregs so
                  // out_valid rises on the cycle after detection.
                  DATA_W'(SYS_PNUM): begin
                     tok_load = 1'b1;
                     tok_data = arg0;
                     tok_kind = 1'b1;
                     state_d  = EMIT;
                  end
                  DATA_W'(SYS_PCHR): begin
                     tok_load = 1'b1;
                     tok_data = arg0;
                     tok_kind = 1'b0;
                     state_d  = EMIT;
                  end
`ifdef SYSCALL_STRING_EN
                  DATA_W'(SYS_PSTR): begin
                     cnt_d   = '0;
                     state_d = STR_RD;
                  end
`endif
                  default: begin
                     err_d  = 1'b1;
                     done_d = 1'b1;
                  end
               endcase
            end
         end
         WR: begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
         RD: state_d = RD_CAP;
         RD_CAP: begin
            load_data_d   = mem_rdata;
            load_signal_d = 1'b1;
            state_d       = IDLE;
            done_d        = 1'b1;
         end
         EMIT: begin
            if (xfer) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
`ifdef SYSCALL_STRING_EN
         STR_RD: state_d = STR_CAP;
         STR_CAP: begin
            if (mem_rdata == '0) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               tok_load = 1'b1;
               tok_data = mem_rdata;
               tok_kind = 1'b0;
               cnt_d    = cnt_q + CNT_W'(1);
               state_d  = STR_EMIT;
            end
         end
         STR_EMIT: begin
            if (xfer) begin
               if (cnt_q == CNT_W'(MAX_STR)) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  // Natural ADDR_W overflow gives the modulo wrap.
                  addr_d  = addr_q + ADDR_W'(1);
                  state_d = STR_RD;
               end
            end
         end
`endif
         HALT: state_d = HALT;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         state_q       <= IDLE;
         sys_q         <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         load_signal_q <= 1'b0;
         load_data_q   <= '0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
`ifdef SYSCALL_STRING_EN
         cnt_q         <= '0;
`endif
      end else begin
         state_q       <= state_d;
         sys_q         <= sys_signal;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         load_signal_q <= load_signal_d;
         load_data_q   <= load_data_d;
         done_q        <= done_d;
         err_q         <= err_d;
`ifdef SYSCALL_STRING_EN
         cnt_q         <= cnt_d;
`endif
      end
   end

   syscall_out_reg #(.DATA_W(DATA_W)) u_out_reg (
      .clk       (clk),
      .clear     (clear),
      .load      (tok_load),
      .load_data (tok_data),
      .load_kind (tok_kind),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_kind  (out_kind),
      .xfer      (xfer)
   );

   assign mem_we = (state_q == WR);
`ifdef SYSCALL_STRING_EN
   assign mem_re = (state_q == RD) || (state_q == STR_RD);
`else
   assign mem_re = (state_q == RD);
`endif
   // Address and write data are gated so the bus idles at zero.
   assign mem_addr    = (mem_we || mem_re) ? addr_q : '0;
   assign mem_wdata   = mem_we ? wdata_q : '0;
   assign load_signal = load_signal_q;
   assign load_data   = load_data_q;
   assign busy        = (state_q != IDLE) && (state_q != HALT);
   assign done        = done_q;
   assign halted      = (state_q == HALT);
   assign err         = err_q;

endmodule

// File: tb/tb_syscall_unit.sv
module tb_syscall_unit;

   logic        clk = 1'b0;
   logic        clear;
   logic        sys_signal;
   logic [47:0] sysregs;
   logic [15:0] mem_addr;
   logic        mem_we, mem_re;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata = '0;
   logic        load_signal;
   logic [15:0] load_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_kind;
   logic        busy, done, halted, err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   syscall_unit #(.DATA_W(16), .ADDR_W(16), .MAX_STR(4)) dut (
      .clk         (clk),
      .clear       (clear),
      .sys_signal  (sys_signal),
      .sysregs     (sysregs),
      .mem_addr    (mem_addr),
      .mem_we      (mem_we),
      .mem_re      (mem_re),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .load_signal (load_signal),
      .load_data   (load_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_kind    (out_kind),
      .busy        (busy),
      .done        (done),
      .halted      (halted),
      .err         (err)
   );

   // Memory model: synchronous write, read data valid the cycle after mem_re.
   logic [15:0] mem [0:65535];
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem_re ? mem[mem_addr] : 16'h0;
   end

   // Output monitor: records transferred tokens, activity counts and
   // stability of a stalled token.
   logic [16:0] obs_mem [0:63];
   int          obs_wr = 0;
   int          wr_cnt = 0;
   int          rd_cnt = 0;
   int          stab_viol = 0;
   logic        hold_pending = 1'b0;
   logic [16:0] held = '0;
   always @(negedge clk) begin
      if (out_valid && hold_pending && {out_kind, out_data} !== held) stab_viol++;
      if (!clear && out_valid && out_ready) begin
         obs_mem[obs_wr[5:0]] = {out_kind, out_data};
         obs_wr++;
      end
      hold_pending = out_valid && !out_ready && !clear;
      held = {out_kind, out_data};
      if (mem_we) wr_cnt++;
      if (mem_re) rd_cnt++;
   end

   logic [16:0] exp_q [$];
   int          obs_rd = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic issue(input logic [15:0] op, input logic [15:0] a0, input logic [15:0] a1);
      sysregs    = {a1, a0, op};
      sys_signal = 1'b1;
      @(posedge clk); #1;
      sys_signal = 1'b0;
   endtask

   task automatic store(input logic [15:0] a, input logic [15:0] d);
      issue(16'd1, a, d);
      tick();
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      @(negedge clk);
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check(tag, {31'd0, out_valid}, 32'd1);
   endtask

   task automatic wait_done(input string tag, input bit toggle);
      bit seen = 1'b0;
      for (int n = 0; n < 80 && !seen; n++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
         else begin
            tick();
            if (toggle) out_ready = ~out_ready;
         end
      end
      check(tag, {31'd0, seen}, 32'd1);
   endtask

   task automatic sb_check(input string tag);
      logic [31:0] o;
      logic [16:0] e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_rd < obs_wr) begin
            o = {15'd0, obs_mem[obs_rd[5:0]]};
            obs_rd++;
         end else begin
            o = 32'hDEAD_0000;
         end
         check(tag, o, {15'd0, e});
      end
      check({tag, "_extra"}, obs_wr - obs_rd, 32'd0);
      obs_rd = obs_wr;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_flags"}, {23'd0, mem_we, mem_re, load_signal, out_valid, out_kind,
                              busy, done, halted, err}, 32'd0);
      check({tag, "_load_data"}, {16'd0, load_data}, 32'd0);
      check({tag, "_out_data"}, {16'd0, out_data}, 32'd0);
      check({tag, "_mem_bus"}, {mem_addr, mem_wdata}, 32'd0);
   endtask

   initial begin
      int wr_snap, rd_snap;
      clear      = 1'b1;
      sys_signal = 1'b0;
      sysregs    = '0;
      out_ready  = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      check_all_zero("reset");
      tick();
      clear = 1'b0;

      // Store
      issue(16'd1, 16'h0010, 16'h00AB);
      @(negedge clk);
      check("store_we", {31'd0, mem_we}, 32'd1);
      check("store_bus", {mem_addr, mem_wdata}, {16'h0010, 16'h00AB});
      check("store_busy_done", {30'd0, busy, done}, 32'd2);
      tick();
      @(negedge clk);
      check("store_end", {30'd0, mem_we, done}, 32'd1);
      check("store_wr_count", wr_cnt, 32'd1);
      $display("store addr=0010 data=00AB");

      // Load: result three cycles after detection
      tick();
      issue(16'd2, 16'h0010, 16'h0000);
      @(negedge clk);
      check("load_re", {mem_re, mem_addr, load_signal}, {1'b1, 16'h0010, 1'b0});
      tick();
      @(negedge clk);
      check("load_c2", {31'd0, load_signal}, 32'd0);
      tick();
      @(negedge clk);
      check("load_c3", {load_signal, done, load_data}, {1'b1, 1'b1, 16'h00AB});
      tick();
      @(negedge clk);
      check("load_sticky", {31'd0, load_signal}, 32'd1);
      $display("load addr=0010 data=%0h", load_data);

      // Character emit clears load_signal
      exp_q.push_back({1'b0, 16'h0041});
      issue(16'd4, 16'h0041, 16'h0000);
      @(negedge clk);
      check("pchr_c1", {load_signal, out_valid, out_kind, out_data}, {1'b0, 1'b1, 1'b0, 16'h0041});
      tick();
      @(negedge clk);
      check("pchr_done", {30'd0, done, out_valid}, 32'd2);
      sb_check("pchr_token");
      $display("pchr 'A'");

      // Number emit under backpressure, plus a dropped request while busy
      out_ready = 1'b0;
      exp_q.push_back({1'b1, 16'd1234});
      issue(16'd3, 16'd1234, 16'h0000);
      @(negedge clk);
      check("pnum_c1", {out_valid, out_kind, out_data}, {1'b1, 1'b1, 16'd1234});
      repeat (3) tick();
      @(negedge clk);
      check("pnum_stall", {busy, out_valid, out_data}, {1'b1, 1'b1, 16'd1234});
      issue(16'd1, 16'h0099, 16'h5555);
      @(negedge clk);
      check("overrun_err", {31'd0, err}, 32'd1);
      check("overrun_no_write", wr_cnt, 32'd1);
      out_ready = 1'b1;
      tick();
      @(negedge clk);
      check("pnum_done", {30'd0, done, out_valid}, 32'd2);
      sb_check("pnum_token");
      $display("pnum 1234 with backpressure");
      do_clear();

      // Unknown opcode
      issue(16'd7, 16'h0000, 16'h0000);
      @(negedge clk);
      check("unknown_op", {29'd0, done, err, busy}, 32'd6);
      $display("unknown opcode 7");
      do_clear();

`ifdef SYSCALL_STRING_EN
      // String with toggling out_ready
      store(16'h0020, 16'h0048);
      store(16'h0021, 16'h0069);
      store(16'h0022, 16'h0021);
      store(16'h0023, 16'h0000);
      exp_q.push_back({1'b0, 16'h0048});
      exp_q.push_back({1'b0, 16'h0069});
      exp_q.push_back({1'b0, 16'h0021});
      issue(16'd5, 16'h0020, 16'h0000);
      wait_done("str_done", 1'b1);
      check("str_err", {31'd0, err}, 32'd0);
      sb_check("str_token");
      $display("pstr \"Hi!\" with toggling ready");
      out_ready = 1'b1;
      tick();

      // Address wrap and character limit
      store(16'hFFFE, 16'h0031);
      store(16'hFFFF, 16'h0032);
      store(16'h0000, 16'h0033);
      store(16'h0001, 16'h0034);
      store(16'h0002, 16'h0035);
      exp_q.push_back({1'b0, 16'h0031});
      exp_q.push_back({1'b0, 16'h0032});
      exp_q.push_back({1'b0, 16'h0033});
      exp_q.push_back({1'b0, 16'h0034});
      issue(16'd5, 16'hFFFE, 16'h0000);
      wait_done("wrap_done", 1'b0);
      check("wrap_err", {31'd0, err}, 32'd1);
      sb_check("wrap_token");
      $display("pstr wrap at FFFE, limit 4");
      do_clear();

      // Clear during the second character
      out_ready = 1'b0;
      exp_q.push_back({1'b0, 16'h0048});
      issue(16'd5, 16'h0020, 16'h0000);
      wait_valid("midclr_first");
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      wait_valid("midclr_second");
      check("midclr_second_data", {16'd0, out_data}, 32'h0069);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      @(negedge clk);
      check("midclr_state", {29'd0, busy, out_valid, done}, 32'd0);
      tick();
      @(negedge clk);
      check("midclr_no_done", {31'd0, done}, 32'd0);
      sb_check("midclr_token");
      $display("pstr cleared mid-string");
      out_ready = 1'b1;
`else
      // String print not built: opcode 5 behaves as unknown
      issue(16'd5, 16'h0020, 16'h0000);
      @(negedge clk);
      check("pstr_unknown", {29'd0, done, err, out_valid}, 32'd6);
      $display("pstr disabled -> unknown");
      do_clear();

      // Clear during a stalled emit
      out_ready = 1'b0;
      issue(16'd3, 16'd5, 16'h0000);
      tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      @(negedge clk);
      check("midclr_state", {29'd0, busy, out_valid, done}, 32'd0);
      tick();
      @(negedge clk);
      check("midclr_no_done", {31'd0, done}, 32'd0);
      sb_check("midclr_token");
      $display("emit cleared mid-operation");
      out_ready = 1'b1;
`endif

      // sys_signal held through clear is a request right after clear
      tick();
      clear      = 1'b1;
      sysregs    = {16'h0000, 16'h005A, 16'd4};
      sys_signal = 1'b1;
      repeat (2) tick();
      clear = 1'b0;
      tick();
      sys_signal = 1'b0;
      @(negedge clk);
      exp_q.push_back({1'b0, 16'h005A});
      check("held_req", {out_valid, out_data}, {1'b1, 16'h005A});
      tick();
      sb_check("held_req_token");
      $display("request held through clear");

      // Halt, then an overrun request
      tick();
      wr_snap = wr_cnt;
      rd_snap = rd_cnt;
      issue(16'd0, 16'h0000, 16'h0000);
      @(negedge clk);
      check("halt_state", {28'd0, halted, busy, done, err}, 32'd8);
      tick();
      issue(16'd4, 16'h0058, 16'h0000);
      repeat (2) tick();
      @(negedge clk);
      check("halt_overrun", {29'd0, halted, err, out_valid}, 32'd6);
      check("halt_no_mem", {wr_cnt - wr_snap, rd_cnt - rd_snap}, 32'd0);
      sb_check("halt_token");
      $display("halt then overrun");
      do_clear();
      @(negedge clk);
      check_all_zero("post_halt_clear");

      check("token_stability", stab_viol, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/syscall_unit.md
SYSCALL_UNIT -- requirements
Module: syscall_unit

Interface
REQ-001 The block SHALL have the parameter DATA_W, default 16, which sets the register and data width.
REQ-002 The block SHALL have the parameter ADDR_W, default 16, which sets the memory address width.
REQ-003 The block SHALL have the parameter MAX_STR, default 256, which sets the maximum number of characters emitted by one string print.
REQ-004 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  the single clock;
- clear  in  1  synchronous, active-high reset;
- sys_signal  in  1  syscall request level; a rising edge is a request;
- sysregs  in  3*DATA_W  [DATA_W-1:0] opcode, next field arg0 (address or value), top field arg1 (write data);
- mem_addr  out  ADDR_W  memory address;
- mem_we  out  1  memory write strobe;
- mem_re  out  1  memory read strobe;
- mem_wdata  out  DATA_W  memory write data;
- mem_rdata  in  DATA_W  read data, valid the cycle after mem_re;
- load_signal  out  1  load_data is valid;
- load_data  out  DATA_W  result of a load;
- out_valid  out  1  output token present;
- out_ready  in  1  consumer accepts the token;
- out_data  out  DATA_W  output token;
- out_kind  out  1  0 = character, 1 = decimal number;
- busy  out  1  a syscall is in progress;
- done  out  1  one-cycle pulse when a syscall completes;
- halted  out  1  sticky halt;
- err  out  1  sticky fault.

Function
REQ-005 The block SHALL register sys_signal and accept a request in the cycle where it is 1 and its registered value is 0, provided the state is IDLE.
REQ-006 On acceptance, the block SHALL latch sysregs and leave IDLE on the next edge.
REQ-007 A rising edge of sys_signal that arrives while busy or halted SHALL be dropped and SHALL set err.
REQ-008 The states SHALL be IDLE, WR, RD, RD_CAP, EMIT, STR_RD, STR_CAP, STR_EMIT and HALT.
REQ-009 Opcode 0 (halt) SHALL enter HALT; halted=1 and busy=0 SHALL hold until clear.
REQ-010 Opcode 1 (store) SHALL hold mem_we=1 for exactly one cycle with mem_addr=arg0[ADDR_W-1:0] and mem_wdata=arg1, then return to IDLE.
REQ-011 Opcode 2 (load) SHALL assert mem_re for one cycle, capture mem_rdata on the following edge, then set load_signal=1 and load_data to the captured value.
REQ-012 load_signal SHALL remain 1 until the next accepted syscall whose opcode is not 2.
REQ-013 An accepted syscall whose opcode is not 2 SHALL clear load_signal in its acceptance cycle.
REQ-014 Opcode 3 SHALL emit arg0 with out_kind=1; opcode 4 SHALL emit arg0 with out_kind=0.
REQ-015 While out_valid=1, out_data and out_kind SHALL stay stable until out_ready=1, and the token SHALL transfer in the cycle where out_valid and out_ready are both 1.
REQ-016 Opcode 5 (string) SHALL read words from address arg0+i, i=0,1,...; a word of 0 SHALL end the syscall without emitting it, and any other word SHALL be emitted as a character.
REQ-017 The string address SHALL wrap modulo 2^ADDR_W.
REQ-018 After MAX_STR characters, a string print SHALL stop and set err, even if no terminator was found.
REQ-019 An unknown opcode SHALL set err and complete immediately.
REQ-020 done SHALL pulse for one cycle on the edge where the state returns to IDLE; busy SHALL be 1 in every state except IDLE and HALT.
REQ-021 When out_ready is held at 1, load latency SHALL be 3 cycles from the detection cycle to load_signal=1, and emit latency SHALL be 1 cycle from the detection cycle to out_valid=1.

Reset
REQ-022 When clear=1 at a clock edge, the state SHALL go to IDLE and every output SHALL be 0: mem_we, mem_re, load_signal, load_data, out_valid, out_data, out_kind, busy, done, halted, err, mem_addr and mem_wdata.
REQ-023 A clear in the middle of an operation SHALL abandon it with no done pulse.
REQ-024 The registered copy of sys_signal SHALL reset to 0, so a sys_signal held at 1 through clear is seen as a request in the first cycle after clear.

Configuration
REQ-025 The macro SYSCALL_STRING_EN SHALL control the string print: when defined, opcode 5 behaves as in REQ-016 to REQ-018; when undefined, opcode 5 is treated as unknown (err=1, done pulse) and the STR_* states and the character counter are not built.

Structure
REQ-026 The package syscall_pkg SHALL hold the opcode constants (SYS_HALT=0, SYS_STORE=1, SYS_LOAD=2, SYS_PNUM=3, SYS_PCHR=4, SYS_PSTR=5) and the state typedef.
REQ-027 The sub-module syscall_out_reg SHALL hold the out_valid/out_data/out_kind holding register and its handshake; no other sub-module SHALL be used.

Verification
REQ-028 Store: sysregs={16'h00AB, 16'h0010, 16'd1} with a rising edge -> one mem_we cycle with addr 0x0010 and wdata 0x00AB; done one cycle later.
REQ-029 Load: mem[0x0010]=0x00AB, opcode 2, arg0=0x0010 -> load_signal=1 and load_data=0x00AB three cycles after detection; a following opcode 4 clears load_signal.
REQ-030 String with backpressure: mem[0x20..0x23]="Hi!",0 and out_ready toggling -> exactly 3 tokens 'H','i','!' with out_kind=0 and none lost or duplicated.
REQ-031 Wrap and limit: MAX_STR=4, string at 0xFFFE with non-zero words -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001 emitted, then err=1.
REQ-032 Halt and overrun: opcode 0, then another edge -> halted=1, err=1, no memory or output activity; clear -> all outputs 0.
REQ-033 Mid-op clear: clear during the 2nd character of a string -> IDLE next cycle, out_valid=0, no done pulse.
